// File: rtl/mem_seq_master.sv
// mem_seq_master: sequential instruction-fetch / data-memory master.
// Fetches one instruction per cycle. Each load or store adds one MEM cycle.
// A halt opcode stops execution until the next reset.
// Optional build macro MEM_SEQ_WRAP_HALT_EN: when the PC would overflow past
// 1023, the core halts (PC held at 1023) instead of wrapping to 0.
module mem_seq_master #(
  parameter logic [5:0] LOAD_OP  = 6'b100110,
  parameter logic [5:0] STORE_OP = 6'b101001,
  parameter logic [5:0] HALT_OP  = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] instruction_in,
  input  logic [15:0] data_in,
  input  logic        stall,
  input  logic [15:0] reg_rdata,
  output logic [9:0]  instruction_addr,
  output logic [9:0]  data_addr,
  output logic [15:0] data_out,
  output logic        data_R,
  output logic        data_W,
  output logic        done,
  output logic [17:0] inst_out,
  output logic        inst_valid,
  output logic [1:0]  reg_raddr,
  output logic        reg_we,
  output logic [1:0]  reg_waddr,
  output logic [15:0] reg_wdata
);

  typedef enum logic [1:0] {StFetch, StMem, StHalt} state_e;

  state_e      r_state, w_state_next;
  logic        r_is_load;
  logic [1:0]  r_dest;
  logic [5:0]  w_opcode;
  logic        w_is_mem_op;
  logic        w_ovf_halt;
  logic [9:0]  w_pc_inc;

  assign w_opcode    = instruction_in[17:12];
  assign w_is_mem_op = (w_opcode == LOAD_OP) || (w_opcode == STORE_OP);
  assign w_pc_inc    = instruction_addr + 10'd1;
  assign reg_raddr   = instruction_in[11:10];

`ifdef MEM_SEQ_WRAP_HALT_EN
  // PC increment out of the last address halts instead of wrapping.
  assign w_ovf_halt = (instruction_addr == 10'd1023);
`else
  assign w_ovf_halt = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch: begin
        if (!stall) begin
          if (w_is_mem_op) begin
            w_state_next = StMem;
          end else if (w_opcode == HALT_OP || w_ovf_halt) begin
            w_state_next = StHalt;
          end
        end
      end
      StMem:   w_state_next = w_ovf_halt ? StHalt : StFetch;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StFetch;
    endcase
  end

  // Registered datapath: PC, memory request, decode and write-back outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_addr <= '0;
      data_addr        <= '0;
      data_out         <= '0;
      data_R           <= 1'b0;
      data_W           <= 1'b0;
      done             <= 1'b0;
      inst_out         <= '0;
      inst_valid       <= 1'b0;
      reg_we           <= 1'b0;
      reg_waddr        <= '0;
      reg_wdata        <= '0;
      r_is_load        <= 1'b0;
      r_dest           <= '0;
    end else begin
      // Single-cycle pulses.
      inst_valid <= 1'b0;
      reg_we     <= 1'b0;
      case (r_state)
        StFetch: begin
          if (!stall) begin
            inst_out   <= instruction_in;
            inst_valid <= 1'b1;
            if (w_is_mem_op) begin
              data_addr <= instruction_in[9:0];
              data_R    <= 1'b1;
              data_W    <= (w_opcode == STORE_OP);
              r_is_load <= (w_opcode == LOAD_OP);
              r_dest    <= instruction_in[11:10];
              if (w_opcode == STORE_OP) begin
                data_out <= reg_rdata;
              end
            end else if (w_opcode == HALT_OP || w_ovf_halt) begin
              done <= 1'b1;
            end else begin
              instruction_addr <= w_pc_inc;
            end
          end
        end
        StMem: begin
          // Access completes regardless of stall.
          data_R <= 1'b0;
          data_W <= 1'b0;
          if (r_is_load) begin
            reg_we    <= 1'b1;
            reg_waddr <= r_dest;
            reg_wdata <= data_in;
          end
          if (w_ovf_halt) begin
            done <= 1'b1;
          end else begin
            instruction_addr <= w_pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_seq_master.md
MEM_SEQ_MASTER -- requirements
Module: mem_seq_master

Interface
REQ-001 SHALL have parameter LOAD_OP, default 6'b100110, meaning the load-from-memory opcode (instruction bits [17:12]).
REQ-002 SHALL have parameter STORE_OP, default 6'b101001, meaning the store-to-memory opcode.
REQ-003 SHALL have parameter HALT_OP, default 6'b111111, meaning the halt opcode.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 instruction_in  in  18  instruction word returned by instruction memory for the current instruction_addr.
REQ-007 data_in  in  16  read data returned by data memory.
REQ-008 stall  in  1  core hold request; blocks decode.
REQ-009 reg_rdata  in  16  register-file read data for reg_raddr.
REQ-010 instruction_addr  out  10  registered fetch address (PC).
REQ-011 data_addr  out  10  registered data-memory address.
REQ-012 data_out  out  16  registered store data.
REQ-013 data_R  out  1  memory access enable.
REQ-014 data_W  out  1  write qualifier; valid only with data_R=1.
REQ-015 done  out  1  sticky halt indication.
REQ-016 inst_out  out  18  last decoded instruction word.
REQ-017 inst_valid  out  1  one-cycle pulse per decoded instruction.
REQ-018 reg_raddr  out  2  combinational, equals instruction_in[11:10].
REQ-019 reg_we, reg_waddr[1:0], reg_wdata[15:0]  out  load write-back port.

Function
REQ-020 Memory side SHALL behave as follows: the memory updates instruction_in/data_in on the falling edge after an address is driven, so data is valid at the next rising edge; data_R=1,data_W=0 means read; data_R=1,data_W=1 means write.
REQ-021 States SHALL be FETCH, MEM, HALT.
REQ-022 In FETCH with stall=0, each rising edge SHALL decode instruction_in: inst_out<=instruction_in, inst_valid<=1.
REQ-023 In FETCH with stall=1, the block SHALL hold instruction_addr and take no other action, with inst_valid=0.
REQ-024 For a non-memory, non-halt opcode, the block SHALL set instruction_addr<=instruction_addr+1 and remain in FETCH, giving a throughput of 1 instruction/cycle.
REQ-025 On LOAD_OP, the block SHALL set data_addr<=instruction_in[9:0], data_R<=1, data_W<=0, latch destination instruction_in[11:10], hold instruction_addr, and enter MEM.
REQ-026 On STORE_OP, the block SHALL perform the same actions as REQ-025 except data_W<=1 and data_out<=reg_rdata sampled at the same edge.
REQ-027 In MEM, the next edge SHALL unconditionally (stall ignored) clear data_R/data_W and increment instruction_addr; for a load it SHALL set reg_we<=1 for one cycle with reg_wdata<=data_in and reg_waddr equal to the latched destination; it SHALL then return to FETCH. A memory op takes 2 cycles.
REQ-028 On HALT_OP, the block SHALL set done<=1, hold instruction_addr, and enter HALT; HALT is exited only by rst.
REQ-029 instruction_addr SHALL wrap from 1023 to 0 (see REQ-034).
REQ-030 data_R SHALL never be asserted in FETCH or HALT; inst_valid and reg_we SHALL never be asserted in the same cycle as each other's source decode (inst_valid only in the cycle after a FETCH decode).

Reset
REQ-031 rst SHALL immediately force instruction_addr=0, data_addr=0, data_out=0, data_R=0, data_W=0, done=0, inst_out=0, inst_valid=0, reg_we=0, reg_waddr=0, reg_wdata=0, and state=FETCH, including when asserted mid-MEM; an in-flight access SHALL be abandoned with no write-back.
REQ-032 The first rising edge after rst deassertion SHALL decode the instruction at address 0.

Configuration
REQ-033 Macro MEM_SEQ_WRAP_HALT_EN SHALL select the PC-overflow behaviour.
REQ-034 With MEM_SEQ_WRAP_HALT_EN defined, incrementing from 1023 SHALL set done<=1 and enter HALT with instruction_addr held at 1023; without it, instruction_addr SHALL wrap to 0 and execution SHALL continue.

Verification
REQ-035 Mem[0]=0x0005, inst[0]=100110_01_0000000000 -> data_R=1,data_W=0,data_addr=0 for 1 cycle; next cycle reg_we=1, reg_waddr=1, reg_wdata=0x0005; instruction_addr=1.
REQ-036 inst[0]=101001_10_0000000011 with reg_rdata=0x0018 -> data_R=1, data_W=1, data_addr=3, data_out=0x0018 for exactly 1 cycle; reg_we stays 0.
REQ-037 Three non-memory opcodes at addresses 0-2, then HALT_OP at 3 -> instruction_addr sequence 0,1,2,3 on consecutive cycles; done=1 from the decode edge of address 3 and stays 1.
REQ-038 stall=1 held for 3 cycles at addr 2 -> instruction_addr stays 2 and inst_valid=0 for 3 cycles, then decode resumes.
REQ-039 rst asserted during MEM of a load -> data_R=0, reg_we never pulses, instruction_addr=0.
REQ-040 PC at 1023 with a non-memory op -> instruction_addr=0 without macro; done=1 and instruction_addr=1023 with MEM_SEQ_WRAP_HALT_EN.
